// File: rtl/dsp_mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// dsp_mac_accumulator_if
//
// Result stream from the frame accumulator to the next stage.
//
// Handshake: a transfer happens on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, the
// producer holds out_data/out_count stable. out_ready is ignored while
// out_valid is low.
//
// Signals:
//   out_valid  producer -> consumer  head entry available
//   out_ready  consumer -> producer  consumer takes the head this cycle
//   out_data   producer -> consumer  frame sum (ACC_W bits)
//   out_count  producer -> consumer  samples in that frame (CNT_W bits)
//
// Modports: master = accumulator side, slave = sink side.
// ---------------------------------------------------------------------------
interface dsp_mac_accumulator_if #(
    parameter int ACC_W = 56,
    parameter int CNT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output out_valid,
        output out_data,
        output out_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_count,
        output out_ready
    );
endinterface

// File: rtl/dsp_mac_accumulator.sv
// ---------------------------------------------------------------------------
// dsp_mac_accumulator
//
// Sits behind a free-running DSP slice with LATENCY cycles of operand-to-P
// delay. The in_valid/in_last sideband travels through a matching shift
// register so it lines up with the P value it describes. Aligned samples are
// summed per frame; at the last sample the sum and sample count are pushed
// into a DEPTH-entry result FIFO, which drains over a valid/ready stream.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       DSP operands presented this cycle
//   in_last        last sample of a frame (qualified by in_valid)
//   p_in           DSP P output, two's complement, P_W bits
//   ovf            sticky: a finished frame was dropped on a full FIFO
//   clr_ovf        clears ovf (and sat when present); a new event wins
//   sat            (only with DSP_ACC_SATURATE_EN) sticky saturation flag
//   out_if         result stream, master side (see dsp_mac_accumulator_if)
//
// Build option: define DSP_ACC_SATURATE_EN for signed saturating sums and the
// sat output. Without it the sum wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module dsp_mac_accumulator #(
    parameter int LATENCY = 4,
    parameter int P_W     = 48,
    parameter int ACC_W   = 56,
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           in_last,
    input  logic [P_W-1:0] p_in,
    output logic           ovf,
    input  logic           clr_ovf,
`ifdef DSP_ACC_SATURATE_EN
    output logic           sat,
`endif
    dsp_mac_accumulator_if.master out_if
);
    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Sideband alignment. Bit 0 takes this cycle's inputs; bit LATENCY-1
    // describes the operands whose P is on p_in right now.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] v_sr;
    logic [LATENCY-1:0] l_sr;
    logic               a_valid;
    logic               a_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr <= LATENCY'({v_sr, in_valid});
            l_sr <= LATENCY'({l_sr, in_valid & in_last});
        end
    end

    assign a_valid = v_sr[LATENCY-1];
    assign a_last  = l_sr[LATENCY-1];

    // ------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum_wrap;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign p_ext    = ACC_W'($signed(p_in));
    assign sum_wrap = acc + p_ext;
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef DSP_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic sum_ovf;

    // Signed overflow: both operands share a sign and the result does not.
    // The clamp direction follows the operands' common sign.
    always_comb begin
        sum_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) &&
                  (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
        if (sum_ovf) begin
            sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = sum_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
        end else if (a_valid && sum_ovf) begin
            sat <= 1'b1;
        end else if (clr_ovf) begin
            sat <= 1'b0;
        end
    end
`else
    assign sum = sum_wrap;
`endif

    // The final sample of a frame goes straight into the FIFO together with
    // the running sum, so the next aligned sample can start a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (a_valid) begin
            if (a_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO. Pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] mem_data [DEPTH];
    logic [CNT_W-1:0] mem_cnt  [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = a_valid & a_last;
    assign pop   = !empty & out_if.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push & (!full | pop);
    assign drop  = push & full & !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_cnt[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_data[wr_ptr[AW-1:0]] <= sum;
                mem_cnt[wr_ptr[AW-1:0]]  <= cnt_inc;
                wr_ptr                   <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Set takes priority over clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = mem_data[rd_ptr[AW-1:0]];
    assign out_if.out_count = mem_cnt[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_dsp_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dsp_mac_accumulator
//
// Bench for dsp_mac_accumulator. The DSP slice is modelled as a queue that
// returns each operand's P value LATENCY cycles after it was presented; frame
// sums, sample counts and the result queue are tracked with plain arithmetic.
// Define DSP_ACC_SATURATE_EN to build against the saturating variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dsp_mac_accumulator;
    localparam int LATENCY = 4;
    localparam int P_W     = 48;
    localparam int ACC_W   = 56;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 4;
    localparam int RW      = CNT_W + ACC_W;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef DSP_ACC_SATURATE_EN
    localparam longint SMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (ACC_W-1));
`endif

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_last;
    logic [P_W-1:0] p_in;
    logic           ovf;
    logic           clr_ovf;
`ifdef DSP_ACC_SATURATE_EN
    logic           sat;
`endif

    always #5 clk = ~clk;

    dsp_mac_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) out_if ();

    dsp_mac_accumulator #(
        .LATENCY(LATENCY), .P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_last  (in_last),
        .p_in     (p_in),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf),
`ifdef DSP_ACC_SATURATE_EN
        .sat      (sat),
`endif
        .out_if   (out_if)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic           v;
        logic           l;
        logic [P_W-1:0] p;
    } op_t;

    op_t              pipe_q[$];   // operands in flight through the DSP
    logic [RW-1:0]    exp_q[$];    // expected results {count, sum}
    logic [ACC_W-1:0] m_sum;
    int               m_cnt;
    logic             m_ovf;
    logic             m_sat;

    int checks   = 0;
    int failures = 0;

    task automatic model_init();
        op_t idle;
        idle = '0;
        pipe_q.delete();
        for (int i = 0; i < LATENCY; i++) pipe_q.push_back(idle);
        exp_q.delete();
        m_sum = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_sat = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Presents one cycle of stimulus, advances the model across the coming
    // edge, then returns 1ns after that edge.
    task automatic tick(input logic v, input logic l, input logic [P_W-1:0] p,
                        input logic rdy, input logic clr);
        op_t              e;
        op_t              n;
        logic [ACC_W-1:0] fsum;
        int               fcnt;
`ifdef DSP_ACC_SATURATE_EN
        longint           s;
`endif
        in_valid         = v;
        in_last          = l;
        out_if.out_ready = rdy;
        clr_ovf          = clr;
        n.v = v;
        n.l = l & v;
        n.p = p;
        pipe_q.push_back(n);
        e    = pipe_q.pop_front();
        p_in = e.v ? e.p : P_W'({$urandom, $urandom});

        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (clr) begin
            m_ovf = 1'b0;
            m_sat = 1'b0;
        end
        if (e.v) begin
`ifdef DSP_ACC_SATURATE_EN
            s = longint'($signed(m_sum)) + longint'($signed(e.p));
            if (s > SMAX) begin
                s = SMAX;
                m_sat = 1'b1;
            end else if (s < SMIN) begin
                s = SMIN;
                m_sat = 1'b1;
            end
            fsum = ACC_W'(s);
`else
            fsum = m_sum + ACC_W'(longint'($signed(e.p)));
`endif
            fcnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (e.l) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({CNT_W'(fcnt), fsum});
                else m_ovf = 1'b1;
                m_sum = '0;
                m_cnt = 0;
            end else begin
                m_sum = fsum;
                m_cnt = fcnt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        in_valid         = 1'b0;
        in_last          = 1'b0;
        clr_ovf          = 1'b0;
        out_if.out_ready = 1'b0;
        p_in             = P_W'({$urandom, $urandom});
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        do_reset();
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_if.out_valid); end
        checks++; if (out_if.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_if.out_data); end
        checks++; if (out_if.out_count !== '0) begin failures++; $display("FAIL reset_out_count got=%0h exp=0", out_if.out_count); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
`ifdef DSP_ACC_SATURATE_EN
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat); end
`endif
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(c < 3, c == 2, P_W'((c + 1) * 10), 1'b1, 1'b0);
            checks++; if (out_if.out_valid !== (c == 6)) begin failures++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, out_if.out_valid, (c == 6)); end
            if (c == 6) begin
                checks++; if (out_if.out_data !== ACC_W'(60)) begin failures++; $display("FAIL basic_data got=%0d exp=60", out_if.out_data); end
                checks++; if (out_if.out_count !== CNT_W'(3)) begin failures++; $display("FAIL basic_count got=%0d exp=3", out_if.out_count); end
            end
        end
    endtask

    task automatic test_single_negative();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick(c == 0, c == 0, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
            checks++; if (out_if.out_valid !== (c == 4)) begin failures++; $display("FAIL neg_valid c=%0d got=%0b exp=%0b", c, out_if.out_valid, (c == 4)); end
            if (c == 4) begin
                checks++; if (out_if.out_data !== 56'hFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL neg_data got=%0h exp=ffffffffffffff", out_if.out_data); end
                checks++; if (out_if.out_count !== CNT_W'(1)) begin failures++; $display("FAIL neg_count got=%0d exp=1", out_if.out_count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [P_W-1:0] ops [3];
        ops[0] = 5; ops[1] = 5; ops[2] = 7;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            tick(c < 3, (c == 1) || (c == 2), (c < 3) ? ops[c] : P_W'(0), c >= 7, 1'b0);
            if (c == 5 || c == 6) begin
                checks++; if ({out_if.out_valid, out_if.out_count, out_if.out_data} !== {1'b1, CNT_W'(2), ACC_W'(10)})
                    begin failures++; $display("FAIL b2b_head1 c=%0d got=%0b/%0d/%0d exp=1/2/10", c, out_if.out_valid, out_if.out_count, out_if.out_data); end
            end
            if (c == 7) begin
                checks++; if ({out_if.out_valid, out_if.out_count, out_if.out_data} !== {1'b1, CNT_W'(1), ACC_W'(7)})
                    begin failures++; $display("FAIL b2b_head2 got=%0b/%0d/%0d exp=1/1/7", out_if.out_valid, out_if.out_count, out_if.out_data); end
            end
            if (c == 8) begin
                checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", out_if.out_valid); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(c < 5, c < 5, P_W'(c + 1), 1'b0, 1'b0);
            if (c == 7 || c == 8) begin
                checks++; if (ovf !== (c == 8)) begin failures++; $display("FAIL ovf_set c=%0d got=%0b exp=%0b", c, ovf, (c == 8)); end
            end
        end
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({out_if.out_valid, out_if.out_count, out_if.out_data} !== {1'b1, CNT_W'(1), ACC_W'(k)})
                begin failures++; $display("FAIL ovf_pop k=%0d got=%0b/%0d/%0d exp=1/1/%0d", k, out_if.out_valid, out_if.out_count, out_if.out_data, k); end
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", out_if.out_valid); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(c < 5, c < 5, P_W'(c + 1), c == 8, 1'b0);
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%0b exp=0", ovf); end
        for (int k = 2; k <= 5; k++) begin
            checks++; if ({out_if.out_valid, out_if.out_data} !== {1'b1, ACC_W'(k)})
                begin failures++; $display("FAIL fullpp_pop k=%0d got=%0b/%0d exp=1/%0d", k, out_if.out_valid, out_if.out_data, k); end
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL fullpp_drained got=%0b exp=0", out_if.out_valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fullpp_ovf_end got=%0b exp=0", ovf); end
    endtask

    // Reset lands once before any sample is aligned and once after two
    // samples have already been summed with the rest still in flight.
    task automatic test_mid_frame_reset();
        int rst_at;
        for (int r = 0; r < 2; r++) begin
            rst_at = (r == 0) ? 3 : 6;
            do_reset();
            for (int c = 0; c < rst_at; c++) begin
                tick(c < 5, c == 4, P_W'($urandom_range(1, 100)), 1'b1, 1'b0);
            end
            do_reset();
            for (int j = 0; j < 7; j++) begin
                tick(j < 2, j == 1, P_W'(j + 2), 1'b1, 1'b0);
                checks++; if (out_if.out_valid !== (j == 5)) begin failures++; $display("FAIL rstmid_valid r=%0d j=%0d got=%0b exp=%0b", r, j, out_if.out_valid, (j == 5)); end
                if (j == 5) begin
                    checks++; if ({out_if.out_count, out_if.out_data} !== {CNT_W'(2), ACC_W'(5)})
                        begin failures++; $display("FAIL rstmid_result r=%0d got=%0d/%0d exp=2/5", r, out_if.out_count, out_if.out_data); end
                end
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic l;
        logic rdy;
        logic exp_v;
        do_reset();
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                v   = ($urandom_range(0, 3) != 0);
                l   = ($urandom_range(0, 3) == 0);
                rdy = ((i % 64) < 32) ? ($urandom_range(0, 2) != 0) : 1'b0;
            end else begin
                v   = 1'b0;
                l   = 1'b0;
                rdy = 1'b1;
            end
            tick(v, l, P_W'({$urandom, $urandom}), rdy, ($urandom_range(0, 15) == 0));
            exp_v = (exp_q.size() != 0);
            checks++; if (out_if.out_valid !== exp_v) begin failures++; $display("FAIL rand_valid i=%0d got=%0b exp=%0b", i, out_if.out_valid, exp_v); end
            if (exp_v) begin
                checks++; if ({out_if.out_count, out_if.out_data} !== exp_q[0])
                    begin failures++; $display("FAIL rand_head i=%0d got=%0h/%0h exp=%0h", i, out_if.out_count, out_if.out_data, exp_q[0]); end
            end
            checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf i=%0d got=%0b exp=%0b", i, ovf, m_ovf); end
`ifdef DSP_ACC_SATURATE_EN
            checks++; if (sat !== m_sat) begin failures++; $display("FAIL rand_sat i=%0d got=%0b exp=%0b", i, sat, m_sat); end
`endif
        end
    endtask

`ifdef DSP_ACC_SATURATE_EN
    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 516; i++) begin
            tick(i < 512, i == 511, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0);
        end
        checks++; if ({out_if.out_valid, out_if.out_data} !== {1'b1, 56'h7F_FFFF_FFFF_FFFF})
            begin failures++; $display("FAIL sat_data got=%0b/%0h exp=1/7fffffffffffff", out_if.out_valid, out_if.out_data); end
        checks++; if (out_if.out_count !== CNT_W'(512)) begin failures++; $display("FAIL sat_count got=%0d exp=512", out_if.out_count); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b exp=1", sat); end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_clear got=%0b exp=0", sat); end
    endtask
`endif

    initial begin
        rst              = 1'b1;
        in_valid         = 1'b0;
        in_last          = 1'b0;
        clr_ovf          = 1'b0;
        p_in             = '0;
        out_if.out_ready = 1'b0;
        model_init();

        test_reset();
        test_basic_frame();
        test_single_negative();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_mid_frame_reset();
        test_random();
`ifdef DSP_ACC_SATURATE_EN
        test_saturate();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_mac_accumulator.md
Name: dsp_mac_accumulator

Overview:
- Sits directly downstream of the 4-stage pre-add/multiply/post-add DSP slice and consumes its 48-bit P result.
- Realigns a sideband valid/last pair, issued alongside the DSP operands, with the P output, then sums P over a frame.
- Pushes each completed frame sum, with its sample count, into a small result FIFO.
- Drains the FIFO through a valid/ready handshake to the next stage, such as a bus or streaming sink.

Parameters:
- LATENCY, 4: DSP operand-to-P latency in clock cycles; delay applied to in_valid/in_last.
- P_W, 48: width of p_in.
- ACC_W, 56: accumulator and out_data width; must be >= P_W.
- CNT_W, 16: frame sample counter width.
- DEPTH, 4: result FIFO depth; must be a power of 2, >= 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  high in the cycle the DSP operands A/B/C/D are presented.
- in_last  in  1  marks the final sample of a frame; qualified by in_valid.
- p_in  in  P_W  DSP P output.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  sink accepts the head this cycle.
- out_data  out  ACC_W  frame sum at FIFO head.
- out_count  out  CNT_W  sample count of the frame at FIFO head.
- ovf  out  1  sticky flag: a result was dropped because the FIFO was full.
- clr_ovf  in  1  clears ovf.

Behaviour:
- Reset: delay line, accumulator, counter, FIFO pointers and ovf cleared. out_valid=0, out_data=0, out_count=0, ovf=0.
- Reset mid-frame discards the partial sum and all in-flight delayed valids. DSP samples already in the pipeline are never counted.
- Alignment: shift register of depth LATENCY carries {in_valid, in_last & in_valid}. The aligned pair (a_valid, a_last) coincides with the p_in produced by the operands presented LATENCY cycles earlier.
- in_last without in_valid is ignored.
- p_in is treated as two's complement and sign-extended to ACC_W.
- a_valid & !a_last: acc <= acc + sext(p_in); cnt <= cnt + 1, saturating at all-ones.
- a_valid & a_last:
  - Push {acc + sext(p_in), cnt + 1 (saturating)} into the FIFO.
  - Next edge: acc <= 0, cnt <= 0.
  - A new frame may begin on the very next aligned sample (back-to-back frames, no bubble).
- !a_valid: acc and cnt hold.
- FIFO output:
  - out_valid = !empty; out_data and out_count are driven from the head entry (registered storage).
  - out_valid is first high the cycle after the push edge.
  - Pop when out_valid & out_ready.
  - Head data stays stable while out_valid & !out_ready.
- Full FIFO:
  - Push while full with no pop in the same cycle: the result is dropped, FIFO unchanged, ovf <= 1.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged, ovf unaffected.
- Empty FIFO: out_ready ignored; pointers unchanged.
- Pointer wrap: modulo DEPTH, with one extra bit to distinguish full from empty.
- ovf:
  - clr_ovf=1 clears ovf.
  - If clr_ovf and a drop occur in the same cycle, set wins (ovf=1).
- No input backpressure: the DSP is free-running, so every aligned sample is consumed.

Optional Feature:
- Macro: DSP_ACC_SATURATE_EN.
- Defined:
  - Accumulation (including the final sum at push) saturates at the signed limits +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
  - An extra output port sat (1 bit) is sticky high once any saturation occurs; it is cleared by rst or clr_ovf.
  - Once saturated, further additions toward the same limit hold at the limit.
- Undefined: the sum wraps modulo 2^ACC_W, and the sat port does not exist.

Test Plan:
1. Release rst, pulse in_valid at cycles 0,1,2 with in_last at cycle 2; drive p_in=10,20,30 at cycles 4,5,6; out_ready=1 -> out_valid first high after the cycle-6 edge with out_data=60, out_count=3, then drops after one cycle.
2. Single-sample frame: in_valid&in_last at cycle 0, p_in=0xFFFF_FFFF_FFFF (-1) at cycle 4 -> out_data=all ones (-1 sign-extended), out_count=1.
3. Back-to-back frames {5,5} then {7} with out_ready=0 -> FIFO holds (10,2) then (7,1). Raising out_ready pops in that order, one per cycle.
4. out_ready=0; push 5 single-sample frames with p_in=1..5 -> first 4 stored, 5th dropped, ovf=1. Pop all -> 1,2,3,4. clr_ovf pulse -> ovf=0.
5. FIFO full with out_ready=1 while a 5th result pushes in the same cycle -> no drop, ovf stays 0, result 5 delivered last.
6. rst asserted for 1 cycle at cycle 3 of a 5-sample frame -> no result emitted for that frame; the next frame {2,3} gives out_data=5, out_count=2. With DSP_ACC_SATURATE_EN, a frame of 0x7FFF_FFFF_FFFF repeated 2^9 times at ACC_W=56 -> out_data=0x7F_FFFF_FFFF_FFFF, sat=1.
